// File: rtl/fir_xifu_result_fifo_pkg.sv
// Shared FIR XIFU types and sizing constants.
//   wb2res_t    : one writeback result (id, data, rd, we) at default XIF widths
//   res_entry_t : a result plus the killed flag the result buffer keeps for it
package fir_xifu_pkg;

    localparam int unsigned XIF_ID_WIDTH   = 4;
    localparam int unsigned X_RFW_WIDTH    = 32;
    localparam int unsigned RES_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [X_RFW_WIDTH-1:0]  data;
        logic [4:0]              rd;
        logic                    we;
    } wb2res_t;

    typedef struct packed {
        wb2res_t res;
        logic    killed;
    } res_entry_t;

endpackage

// File: rtl/fir_xifu_result_fifo_if.sv
// Valid/ready result channel bundle (WB -> buffer, buffer -> core).
//   valid/id/data/rd/we : driven by the producing side (master)
//   ready               : driven by the consuming side (slave)
interface fir_xifu_result_fifo_if
    import fir_xifu_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = XIF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH = X_RFW_WIDTH
) ();

    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [4:0]            rd;
    logic                  we;

    modport master (output valid, output id, output data, output rd, output we, input ready);
    modport slave  (input valid, input id, input data, input rd, input we, output ready);

endinterface

// File: rtl/fir_xifu_result_fifo.sv
// In-order result buffer between the FIR XIFU writeback stage and the CV-XIF
// result channel. Absorbs result_ready back-pressure and silently drops
// results whose instruction id the core kills at commit.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync flush)
//   in_*      : WB push side, in_ready_o = not full (registered state only)
//   kill_*    : commit kill strobe and id
//   result_*  : XIF result channel, head entry or zero when empty
//   count_o   : occupied entries, killed ones included
module fir_xifu_result_fifo
    import fir_xifu_pkg::*;
#(
    parameter int unsigned DEPTH      = RES_FIFO_DEPTH,
    parameter int unsigned ID_WIDTH   = XIF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH = X_RFW_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ID_WIDTH-1:0]     in_id_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [4:0]              in_rd_i,
    input  logic                    in_we_i,
    input  logic                    kill_valid_i,
    input  logic [ID_WIDTH-1:0]     kill_id_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [ID_WIDTH-1:0]     result_id_o,
    output logic [DATA_WIDTH-1:0]   result_data_o,
    output logic [4:0]              result_rd_o,
    output logic                    result_we_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [4:0]            rd;
        logic                  we;
    } slot_t;

    slot_t             mem [DEPTH];
    logic [DEPTH-1:0]  killed_q;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
    logic              head_killed;
    logic              push;
    logic              pop;
    logic              push_killed;
    logic [DEPTH-1:0]  kill_hit;
    slot_t             head;

    // Distance of a slot from the head, modulo DEPTH.
    function automatic logic [AW:0] slot_offset(input logic [AW-1:0] slot,
                                                input logic [AW-1:0] hd);
        logic [AW-1:0] d;
        d = slot - hd;
        return {1'b0, d};
    endfunction

    assign wr_idx      = wr_ptr[AW-1:0];
    assign rd_idx      = rd_ptr[AW-1:0];
    assign count       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign head_killed = killed_q[rd_idx];

    assign push        = in_valid_i && !full;
    // A killed head drains silently; a live head leaves on handshake.
    assign pop         = !empty && (head_killed || result_ready_i);
    assign push_killed = kill_valid_i && (in_id_i == kill_id_i);

    // Only occupied slots may be marked; free slots hold stale ids.
    always_comb begin
        kill_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_hit[i] = kill_valid_i
                       && (slot_offset(AW'(i), rd_idx) < count)
                       && (mem[i].id == kill_id_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            killed_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            killed_q <= '0;
        end else begin
            // Later assignments override: a popped head's flag is cleared
            // even if it was hit by a kill this cycle (handshake wins), and
            // the push slot is never occupied, so its write is independent.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_hit[i]) begin
                    killed_q[i] <= 1'b1;
                end
            end
            if (pop) begin
                killed_q[rd_idx] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_idx]      <= '{id: in_id_i, data: in_data_i, rd: in_rd_i, we: in_we_i};
                killed_q[wr_idx] <= push_killed;
                wr_ptr           <= wr_ptr + 1'b1;
            end
        end
    end

    assign head           = empty ? '0 : mem[rd_idx];
    assign in_ready_o     = !full;
    assign result_valid_o = !empty && !head_killed;
    assign result_id_o    = head.id;
    assign result_data_o  = head.data;
    assign result_rd_o    = head.rd;
    assign result_we_o    = head.we;
    assign count_o        = count;

endmodule

// File: doc/fir_xifu_result_fifo.md
Name: fir_xifu_result_fifo

Overview:
- In-order result buffer between the FIR XIFU writeback stage and the core's CV-XIF result channel.
- Absorbs core back-pressure on result_ready, so WB keeps retiring into the buffer while the core stalls.
- Drops results of instructions the core kills at commit.
- Instantiated in fir_xifu_top between the WB result output and the xif_result_o modport.

Parameters:
- DEPTH, 4, number of result entries; power of two, >= 2.
- ID_WIDTH, 4, width of the XIF instruction id.
- DATA_WIDTH, 32, width of the result data (X_RFW_WIDTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous flush of all entries.
- in_valid_i  in  1  WB presents a result.
- in_ready_o  out  1  buffer accepts; equals not-full.
- in_id_i  in  ID_WIDTH  instruction id.
- in_data_i  in  DATA_WIDTH  result data.
- in_rd_i  in  5  destination register.
- in_we_i  in  1  register write enable.
- kill_valid_i  in  1  commit channel kill strobe (commit_valid and commit_kill).
- kill_id_i  in  ID_WIDTH  id being killed.
- result_valid_o  out  1  XIF result_valid.
- result_ready_i  in  1  XIF result_ready.
- result_id_o  out  ID_WIDTH  XIF result id.
- result_data_o  out  DATA_WIDTH  XIF result data.
- result_rd_o  out  5  XIF result rd.
- result_we_o  out  1  XIF result we.
- count_o  out  $clog2(DEPTH)+1  occupied entries, killed entries included.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - Pointers and count are 0; all entry valid/killed flags are 0.
  - in_ready_o=1, result_valid_o=0, result_* data outputs are 0, count_o=0.
- Storage: circular buffer of DEPTH entries {id, data, rd, we, killed}. Write and read pointers are $clog2(DEPTH) bits plus one wrap bit.
  - full = (ptrs equal except wrap bit); empty = (ptrs fully equal).
- Push: in_valid_i && in_ready_o writes at the write pointer on the clock edge; the write pointer increments and wraps at DEPTH.
- No fall-through: a result pushed in cycle N is first visible on result_* in cycle N+1.
- in_ready_o depends only on registered state (no combinational path from result_ready_i). When full, no push occurs even if a pop happens in the same cycle.
- Head presentation: result_valid_o = !empty && !head.killed; result_* show the head entry, or 0 when empty.
- Pop conditions:
  - result_valid_o && result_ready_i pops the head.
  - A killed head is popped silently, one entry per cycle, without asserting result_valid_o.
- Simultaneous push and pop in the same cycle is supported; count_o is unchanged.
- Kill: on kill_valid_i, every stored entry with id == kill_id_i sets killed=1 at the next edge.
  - If the push in that cycle carries the same id, the entry is written with killed=1.
  - If the killed entry is the current head, result_valid_o deasserts the next cycle even without a handshake. This is legal because the core no longer expects that id.
- A kill and a handshake on the head in the same cycle: the handshake wins; the entry leaves normally.
- clear_i: pointers, count and flags go to 0 at the next edge. Any push in that cycle is discarded. clear_i has priority over push, pop and kill.
- Ordering: results leave in push order; ids are never reordered.
- Stability: while result_valid_o=1 and result_ready_i=0, all result_* outputs stay constant, except for a kill of the head as above.

Decomposition:
- fir_xifu_pkg gains:
  - wb2res_t (id, data, rd, we);
  - res_entry_t (wb2res_t plus killed);
  - localparam RES_FIFO_DEPTH = 4.
- Top-level ports stay flat for XIF modport mapping.
- No sub-module is needed; a single-module FIFO with kill-flag update logic is sufficient.

Test Plan:
- Basic pass-through: push id=1, data=0xCAFE0001, rd=5, we=1 with result_ready_i=1 -> result_valid_o=1 with those fields exactly one cycle later; count_o returns to 0 after that.
- Back-pressure and full: result_ready_i=0, push ids 0..3 -> count_o=4, in_ready_o=0, and a 5th push is not accepted. Then hold ready=1 -> results appear with ids 0,1,2,3 in order on consecutive cycles.
- Wrap-around: 10 push/pop pairs with DEPTH=4 and random ready gaps -> every id comes out once, in order, with data intact.
- Kill mid-queue: fill ids 2,3,4 with ready=0, kill id 3, then ready=1 -> outputs are id 2 then id 4. Exactly one idle cycle appears between them (silent pop of 3).
- Kill race: kill id 7 in the same cycle as pushing id 7 -> id 7 is never presented. Separately, head id 1 presented with ready=1 and kill id 1 in the same cycle -> the handshake completes once.
- Reset and clear: assert rst_i asynchronously mid-stream, and clear_i with 3 entries plus a simultaneous push -> result_valid_o=0 and count_o=0 next cycle, in_ready_o=1, and no stale entry ever reappears.
